alu_main_4bit: RTL and testbench

Registered 4-bit ALU (the `alu_main` DUT) for small datapaths and the analog/digital co-simulation flow. Two select bits choose one of four operations: add, subtract, magnitude compare, bitwise AND. The selected result is captured into output registers one clock after a valid request. It is a leaf block with no internal state beyond its output registers.

---
 rtl/alu_main_4bit_if.sv | 25 ++
 rtl/alu_main_4bit.sv | 53 +++++
 tb/tb_alu_main_4bit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_main_4bit_if.sv
// Request/result bundle for alu_main_4bit: operands and select in, registered result groups out.
interface alu_main_4bit_if;
    logic       in_valid;
    logic       select0;
    logic       select1;
    logic [3:0] bit1;
    logic [3:0] bit2;
    logic [4:0] result1;
    logic [4:0] result2;
    logic       equal;
    logic       greater;
    logic       lesser;
    logic [4:0] result4;
    logic       out_valid;

    modport master (
        output in_valid, select0, select1, bit1, bit2,
        input  result1, result2, equal, greater, lesser, result4, out_valid
    );

    modport slave (
        input  in_valid, select0, select1, bit1, bit2,
        output result1, result2, equal, greater, lesser, result4, out_valid
    );
endinterface

// File: rtl/alu_main_4bit.sv
// Registered 4-bit ALU: add, subtract, unsigned compare, AND with one-cycle latency.
// Define ALU_MAIN_HOLD_EN to keep non-selected result groups instead of clearing them.
module alu_main_4bit (
    input logic           clk,
    input logic           rst_n,
    alu_main_4bit_if.slave bus
);

    logic [1:0] op;
    logic [4:0] sum;
    logic [4:0] diff;

    assign op = {bus.select1, bus.select0};
    assign sum = {1'b0, bus.bit1} + {1'b0, bus.bit2};
    // 5-bit wrap leaves the borrow in bit 4
    assign diff = {1'b0, bus.bit1} - {1'b0, bus.bit2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result1   <= 5'd0;
            bus.result2   <= 5'd0;
            bus.equal     <= 1'b0;
            bus.greater   <= 1'b0;
            bus.lesser    <= 1'b0;
            bus.result4   <= 5'd0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
`ifndef ALU_MAIN_HOLD_EN
                // Clear every group; the selected one is overwritten below
                bus.result1 <= 5'd0;
                bus.result2 <= 5'd0;
                bus.equal   <= 1'b0;
                bus.greater <= 1'b0;
                bus.lesser  <= 1'b0;
                bus.result4 <= 5'd0;
`endif
                unique case (op)
                    2'b00: bus.result1 <= sum;
                    2'b01: bus.result2 <= diff;
                    2'b10: begin
                        bus.equal   <= (bus.bit1 == bus.bit2);
                        bus.greater <= (bus.bit1 > bus.bit2);
                        bus.lesser  <= (bus.bit1 < bus.bit2);
                    end
                    default: bus.result4 <= {1'b0, bus.bit1 & bus.bit2};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_main_4bit.sv
// Directed self-checking bench for alu_main_4bit; expected values are hand-computed constants.
module tb_alu_main_4bit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Expected contents of each result group; flags packed as {equal, greater, lesser}
    logic [4:0] g_r1, g_r2, g_r4;
    logic [2:0] g_f;

    alu_main_4bit_if bus ();

    alu_main_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] obs_vec();
        return {bus.result1, bus.result2, bus.equal, bus.greater, bus.lesser, bus.result4,
                bus.out_valid};
    endfunction

    function automatic void clear_expect();
        g_r1 = 5'd0;
        g_r2 = 5'd0;
        g_f  = 3'd0;
        g_r4 = 5'd0;
    endfunction

    // Record the hand-computed result of a request for the selected group
    function automatic void set_expect(input logic [1:0] op, input logic [4:0] val);
`ifndef ALU_MAIN_HOLD_EN
        clear_expect();
`endif
        case (op)
            2'b00:   g_r1 = val;
            2'b01:   g_r2 = val;
            2'b10:   g_f  = val[2:0];
            default: g_r4 = val;
        endcase
    endfunction

    task automatic drive(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        {bus.select1, bus.select0} = op;
        bus.bit1 = a;
        bus.bit2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic [3:0] junk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        {bus.select1, bus.select0} = junk[1:0];
        bus.bit1 = junk;
        bus.bit2 = ~junk;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        {bus.select1, bus.select0} = 2'b00;
        bus.bit1 = 4'hF;
        bus.bit2 = 4'hF;
        clear_expect();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== 19'd0) begin
            errors++;
            $display("FAIL reset: got %b expected %b", obs_vec(), 19'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        drive(2'b00, 4'b0110, 4'b1100);
        set_expect(2'b00, 5'b10010);
        checks++;
        if (obs_vec() !== {g_r1, g_r2, g_f, g_r4, 1'b1}) begin
            errors++;
            $display("FAIL add: got %b expected %b", obs_vec(), {g_r1, g_r2, g_f, g_r4, 1'b1});
        end
    endtask

    task automatic test_sub();
        logic [3:0] a [2] = '{4'b1010, 4'b0010};
        logic [3:0] b [2] = '{4'b0010, 4'b0101};
        logic [4:0] e [2] = '{5'b01000, 5'b11101};
        for (int i = 0; i < 2; i++) begin
            drive(2'b01, a[i], b[i]);
            set_expect(2'b01, e[i]);
            checks++;
            if (obs_vec() !== {g_r1, g_r2, g_f, g_r4, 1'b1}) begin
                errors++;
                $display("FAIL sub[%0d]: got %b expected %b", i, obs_vec(),
                         {g_r1, g_r2, g_f, g_r4, 1'b1});
            end
        end
    endtask

    task automatic test_compare();
        logic [3:0] a [3] = '{4'b1011, 4'b1100, 4'b1111};
        logic [3:0] b [3] = '{4'b1111, 4'b1100, 4'b0000};
        logic [2:0] e [3] = '{3'b001, 3'b100, 3'b010};
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, a[i], b[i]);
            set_expect(2'b10, {2'b00, e[i]});
            checks++;
            if (obs_vec() !== {g_r1, g_r2, g_f, g_r4, 1'b1}) begin
                errors++;
                $display("FAIL cmp[%0d]: got %b expected %b", i, obs_vec(),
                         {g_r1, g_r2, g_f, g_r4, 1'b1});
            end
        end
    endtask

    task automatic test_and();
        logic [3:0] a [2] = '{4'b1111, 4'b1011};
        logic [3:0] b [2] = '{4'b0000, 4'b0110};
        logic [4:0] e [2] = '{5'b00000, 5'b00010};
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, a[i], b[i]);
            set_expect(2'b11, e[i]);
            checks++;
            if (obs_vec() !== {g_r1, g_r2, g_f, g_r4, 1'b1}) begin
                errors++;
                $display("FAIL and[%0d]: got %b expected %b", i, obs_vec(),
                         {g_r1, g_r2, g_f, g_r4, 1'b1});
            end
        end
    endtask

    task automatic test_idle_hold();
        drive(2'b00, 4'b1001, 4'b0011);
        set_expect(2'b00, 5'b01100);
        for (int i = 0; i < 3; i++) begin
            idle_cycle(4'(i * 5 + 3));
            checks++;
            if (obs_vec() !== {g_r1, g_r2, g_f, g_r4, 1'b0}) begin
                errors++;
                $display("FAIL idle[%0d]: got %b expected %b", i, obs_vec(),
                         {g_r1, g_r2, g_f, g_r4, 1'b0});
            end
        end
    endtask

    task automatic test_back_to_back();
        // add, AND, subtract on consecutive edges; in HOLD builds result1 keeps the add value
        drive(2'b00, 4'b1111, 4'b1111);
        set_expect(2'b00, 5'b11110);
        checks++;
        if (obs_vec() !== {g_r1, g_r2, g_f, g_r4, 1'b1}) begin
            errors++;
            $display("FAIL b2b_add: got %b expected %b", obs_vec(), {g_r1, g_r2, g_f, g_r4, 1'b1});
        end
        drive(2'b11, 4'b1100, 4'b0101);
        set_expect(2'b11, 5'b00100);
        checks++;
        if (obs_vec() !== {g_r1, g_r2, g_f, g_r4, 1'b1}) begin
            errors++;
            $display("FAIL b2b_and: got %b expected %b", obs_vec(), {g_r1, g_r2, g_f, g_r4, 1'b1});
        end
        drive(2'b01, 4'b0000, 4'b0001);
        set_expect(2'b01, 5'b11111);
        checks++;
        if (obs_vec() !== {g_r1, g_r2, g_f, g_r4, 1'b1}) begin
            errors++;
            $display("FAIL b2b_sub: got %b expected %b", obs_vec(), {g_r1, g_r2, g_f, g_r4, 1'b1});
        end
        idle_cycle(4'h0);
    endtask

    task automatic test_reset_mid_op();
        drive(2'b00, 4'b0111, 4'b0001);
        set_expect(2'b00, 5'b01000);
        // Assert reset between edges with a second request still presented
        #2;
        rst_n = 1'b0;
        bus.bit1 = 4'hA;
        clear_expect();
        #1;
        checks++;
        if (obs_vec() !== 19'd0) begin
            errors++;
            $display("FAIL rst_async: got %b expected %b", obs_vec(), 19'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== 19'd0) begin
            errors++;
            $display("FAIL rst_release: got %b expected %b", obs_vec(), 19'd0);
        end
        drive(2'b11, 4'b1110, 4'b0111);
        set_expect(2'b11, 5'b00110);
        checks++;
        if (obs_vec() !== {g_r1, g_r2, g_f, g_r4, 1'b1}) begin
            errors++;
            $display("FAIL rst_first_req: got %b expected %b", obs_vec(),
                     {g_r1, g_r2, g_f, g_r4, 1'b1});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.select0 = 1'b0;
        bus.select1 = 1'b0;
        bus.bit1 = 4'h0;
        bus.bit2 = 4'h0;
        clear_expect();
        test_reset();
        test_add();
        test_sub();
        test_compare();
        test_and();
        test_idle_hold();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
